spi_slave_if: RTL and testbench

Serial front end of the FunctionGenerator control path. Brings the external SPI lines (int_clk_i, int_mosi_i, int_cs_i) into the sys_clk_i domain, deserialises MOSI into bytes and returns a byte on MISO. Feeds the command/register decoder downstream with one-cycle byte strobes and frame delimiters. SPI mode 0, MSB first; the first byte of a frame is the command (e.g. 0xC0), the following bytes are data (e.g. 0xAA).

---
 rtl/spi_slave_if_pkg.sv | 9 +
 rtl/spi_slave_if_if.sv | 15 +
 rtl/spi_slave_if_bit_sync.sv | 16 +
 rtl/spi_slave_if.sv | 87 ++++++++
 tb/tb_spi_slave_if.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_if_pkg.sv
// spi_slave_if_pkg: shared constants and types for the SPI slave front end and its downstream decoder.
package spi_slave_if_pkg;
  localparam logic RST_ACT = 1'b0;
  localparam int SPI_W = 8;
  localparam int CNT_W = $clog2(SPI_W);
  localparam int SYNC_STAGES_DEF = 2;
  localparam logic [SPI_W-1:0] CMD_WR = 8'hC0;
  typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/spi_slave_if_if.sv
// spi_slave_if_if: SPI pins plus the byte-strobe bus towards the command decoder.
interface spi_slave_if_if;
  import spi_slave_if_pkg::*;
  logic int_clk_i, int_mosi_i, int_cs_i, int_miso_o;
  logic [SPI_W-1:0] rx_data_o, tx_data_i;
  logic rx_valid_o, rx_first_o, frame_start_o, frame_end_o, tx_req_o;
  modport slave(
    input int_clk_i, int_mosi_i, int_cs_i, tx_data_i,
    output int_miso_o, rx_data_o, rx_valid_o, rx_first_o, frame_start_o, frame_end_o, tx_req_o
  );
  modport master(
    output int_clk_i, int_mosi_i, int_cs_i, tx_data_i,
    input int_miso_o, rx_data_o, rx_valid_o, rx_first_o, frame_start_o, frame_end_o, tx_req_o
  );
endinterface

// File: rtl/spi_slave_if_bit_sync.sv
// bit_sync: N-flop synchroniser with async active-low reset to a chosen idle value.
module bit_sync #(
  parameter int N = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [N-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= {N{RST_VAL}};
    else ff <= {ff[N-2:0], d};
  assign q = ff[N-1];
endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI mode-0 slave front end, MSB first, received bytes delivered as one-cycle strobes.
// Define SPI_MISO_EN to build the MISO transmit path; otherwise MISO and tx_req_o are tied low.
module spi_slave_if
  import spi_slave_if_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  spi_slave_if_if.slave bus
);
  logic sclk_s, mosi_s, cs_s, sclk_d, cs_d;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, start, stop, bit_in, byte_done;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [SPI_W-1:0] rx_sh, rx_data;
  logic first, rx_valid, rx_first, frame_start, frame_end;
  bit_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (.clk(sys_clk_i), .rst_n(sys_rst_i), .d(bus.int_clk_i), .q(sclk_s));
  bit_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.clk(sys_clk_i), .rst_n(sys_rst_i), .d(bus.int_mosi_i), .q(mosi_s));
  bit_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (.clk(sys_clk_i), .rst_n(sys_rst_i), .d(bus.int_cs_i), .q(cs_s));
  always_ff @(posedge sys_clk_i or negedge sys_rst_i)
    if (sys_rst_i == RST_ACT) begin
      state <= IDLE;
      sclk_d <= 1'b0;
      cs_d <= 1'b1;
    end else begin
      state <= state_nx;
      sclk_d <= sclk_s;
      cs_d <= cs_s;
    end
  always_comb state_nx = (state == IDLE && cs_fall) ? ACTIVE : (state == ACTIVE && cs_rise) ? IDLE : state;
  // A CS rise masks any SCLK edge seen in the same cycle.
  always_comb begin
    sclk_rise = sclk_s & ~sclk_d;
    sclk_fall = ~sclk_s & sclk_d;
    cs_fall = ~cs_s & cs_d;
    cs_rise = cs_s & ~cs_d;
    start = state == IDLE && cs_fall;
    stop = state == ACTIVE && cs_rise;
    bit_in = state == ACTIVE && !cs_rise && sclk_rise;
    byte_done = bit_in && cnt == CNT_W'(SPI_W - 1);
  end
  always_ff @(posedge sys_clk_i or negedge sys_rst_i)
    if (sys_rst_i == RST_ACT) begin
      cnt <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      first <= 1'b0;
      rx_valid <= 1'b0;
      rx_first <= 1'b0;
      frame_start <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      cnt <= (start || stop) ? '0 : bit_in ? cnt + 1'b1 : cnt;
      rx_sh <= bit_in ? {rx_sh[SPI_W-2:0], mosi_s} : rx_sh;
      rx_data <= byte_done ? {rx_sh[SPI_W-2:0], mosi_s} : rx_data;
      first <= start ? 1'b1 : byte_done ? 1'b0 : first;
      rx_valid <= byte_done;
      rx_first <= byte_done && first;
      frame_start <= start;
      frame_end <= stop;
    end
  assign bus.rx_data_o = rx_data;
  assign bus.rx_valid_o = rx_valid;
  assign bus.rx_first_o = rx_first;
  assign bus.frame_start_o = frame_start;
  assign bus.frame_end_o = frame_end;
`ifdef SPI_MISO_EN
  logic [SPI_W-1:0] tx_sh;
  logic tx_req, bit_out;
  // The fall right after a byte's last rise (cnt back at 0) must not shift, so the new bit 7 survives.
  assign bit_out = state == ACTIVE && !cs_rise && sclk_fall && cnt != '0;
  always_ff @(posedge sys_clk_i or negedge sys_rst_i)
    if (sys_rst_i == RST_ACT) begin
      tx_req <= 1'b0;
      tx_sh <= '0;
    end else begin
      tx_req <= start || byte_done;
      tx_sh <= stop ? '0 : (tx_req && state == ACTIVE) ? bus.tx_data_i : bit_out ? {tx_sh[SPI_W-2:0], 1'b0} : tx_sh;
    end
  assign bus.int_miso_o = tx_sh[SPI_W-1];
  assign bus.tx_req_o = tx_req;
`else
  assign bus.int_miso_o = 1'b0;
  assign bus.tx_req_o = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: bench acting as SPI master; a byte-level expectation queue is checked every cycle.
module tb_spi_slave_if;
  import spi_slave_if_pkg::*;
`ifdef SPI_MISO_EN
  localparam bit MISO_EN = 1'b1;
`else
  localparam bit MISO_EN = 1'b0;
`endif
  localparam int HALF = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;
  spi_slave_if_if bus();
  spi_slave_if #(.SYNC_STAGES(2)) dut (.sys_clk_i(clk), .sys_rst_i(rst_n), .bus(bus));
  int checks = 0, errs = 0;
  int n_fs = 0, n_fe = 0, n_req = 0, cs_hi = 0;
  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic [7:0] last = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outs", int'({bus.int_miso_o, bus.rx_data_o, bus.rx_valid_o, bus.rx_first_o,
                             bus.frame_start_o, bus.frame_end_o, bus.tx_req_o}), 0);
      last = 8'h00;
      cs_hi = 0;
    end else begin
      cs_hi = bus.int_cs_i ? cs_hi + 1 : 0;
      if (cs_hi > 6) chk("idle_miso", int'(bus.int_miso_o), 0);
      if (bus.rx_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("rx_unexpected", int'(bus.rx_data_o), -1);
          last = bus.rx_data_o;
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", int'(bus.rx_data_o), int'(e[7:0]));
          chk("rx_first", int'(bus.rx_first_o), int'(e[8]));
          last = e[7:0];
        end
      end else chk("rx_hold", int'(bus.rx_data_o), int'(last));
      n_fs += int'(bus.frame_start_o);
      n_fe += int'(bus.frame_end_o);
      n_req += int'(bus.tx_req_o);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.int_mosi_i = tx[7-i];
      tick(HALF);
      bus.int_clk_i = 1'b1;
      rx = {rx[6:0], bus.int_miso_o};
      tick(HALF);
      bus.int_clk_i = 1'b0;
    end
  endtask

  task automatic frame_begin(input logic [7:0] txd);
    int lat;
    lat = 0;
    bus.tx_data_i = txd;
    bus.int_cs_i = 1'b0;
    while (!bus.frame_start_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("fs_latency_ok", int'(lat >= 3 && lat <= 4), 1);
    tick(2);
  endtask

  task automatic frame_end();
    tick(HALF);
    bus.int_cs_i = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    bus.int_cs_i = 1'b1;
    bus.int_clk_i = 1'b0;
    tick(20);
    rst_n = 1'b1;
    tick(10);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r0, r1;
    int b_fs, b_fe, b_req;
    bus.int_clk_i = 1'b0;
    bus.int_mosi_i = 1'b0;
    bus.int_cs_i = 1'b1;
    bus.tx_data_i = 8'h00;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 125; i++) begin
      bus.int_clk_i = ~bus.int_clk_i;
      bus.int_mosi_i = i[1];
      bus.int_cs_i = (i >= 40 && i < 90) ? 1'b0 : 1'b1;
      tick(4);
    end
    bus.int_clk_i = 1'b0;
    bus.int_cs_i = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(10);
    chk("post_rst_fs", n_fs, 0);
    chk("post_rst_req", n_req, 0);

    b_fs = n_fs; b_fe = n_fe; b_req = n_req;
    exp_q.push_back({1'b1, CMD_WR});
    exp_q.push_back({1'b0, 8'hAA});
    frame_begin(8'h5A);
    bus.tx_data_i = 8'h3C;
    xfer(CMD_WR, 8, r0);
    xfer(8'hAA, 8, r1);
    frame_end();
    chk("f1_miso0", int'(r0), MISO_EN ? 32'h5A : 32'h00);
    chk("f1_miso1", int'(r1), MISO_EN ? 32'h3C : 32'h00);
    chk("f1_fs", n_fs - b_fs, 1);
    chk("f1_fe", n_fe - b_fe, 1);
    chk("f1_req", n_req - b_req, MISO_EN ? 3 : 0);
    chk("f1_left", exp_q.size(), 0);
    chk("f1_hold", int'(bus.rx_data_o), 8'hAA);

    b_fe = n_fe;
    frame_begin(8'h00);
    xfer(8'hFF, 5, r0);
    frame_end();
    chk("part_fe", n_fe - b_fe, 1);
    chk("part_hold", int'(bus.rx_data_o), 8'hAA);
    exp_q.push_back({1'b1, 8'h81});
    frame_begin(8'h00);
    xfer(8'h81, 8, r0);
    frame_end();
    chk("f3_data", int'(bus.rx_data_o), 8'h81);
    chk("f3_left", exp_q.size(), 0);

    b_fs = n_fs; b_req = n_req;
    for (int i = 0; i < 16; i++) begin
      bus.int_clk_i = ~bus.int_clk_i;
      bus.int_mosi_i = i[0];
      tick(HALF);
    end
    bus.int_clk_i = 1'b0;
    tick(HALF);
    chk("idle_fs", n_fs - b_fs, 0);
    chk("idle_req", n_req - b_req, 0);
    chk("idle_data", int'(bus.rx_data_o), 8'h81);

    frame_begin(8'h5A);
    xfer(CMD_WR, 4, r0);
    pulse_reset();
    chk("mid_rst_data", int'(bus.rx_data_o), 0);
    exp_q.push_back({1'b1, CMD_WR});
    frame_begin(8'h5A);
    xfer(CMD_WR, 8, r0);
    frame_end();
    chk("f5_miso", int'(r0), MISO_EN ? 32'h5A : 32'h00);
    chk("f5_data", int'(bus.rx_data_o), int'(CMD_WR));
    chk("f5_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
